// File: rtl/alu_response_checker.sv
// alu_response_checker
// Self-checking monitor for the 4-bit ALU. Each cycle of a run it captures the
// ALU's inputs and outputs, recomputes {C,Y} with an independent golden model
// one cycle later, and keeps a vector count, a saturating mismatch count and
// the first failing vector. A run ends with done/pass for the harness.
module alu_response_checker #(
  parameter int NUM_CHECKS = 64,  // vectors per run, 1..255
  parameter int ERR_W      = 8    // mismatch counter width (saturating)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             E,
  input  logic [1:0]       S,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  input  logic [3:0]       Y,
  input  logic             C,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       chk_count,
  output logic [15:0]      first_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index of the final capture; the RUN edge that captures it moves to DRAIN.
  localparam logic [7:0]       LAST_CAP = 8'(NUM_CHECKS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       cap_cnt_q;

  // Stage 1: captured vector {E,S,A,B,Y,C} and its valid flag.
  logic             v1_q;
  logic [15:0]      vec_q;

  // Stage 2: compare result and run statistics.
  logic             mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       chk_q, chk_d;
  logic [15:0]      first_q, first_d;

  // A start pulse is honoured only between runs; it clears the statistics.
  logic             run_clear;
  assign run_clear = start && ((state_q == IDLE) || (state_q == DONE));

  // Run sequencing FSM with registered busy/done.
  // NOTE: every clocked register uses non-blocking assignment so all
  // flops sample the pre-edge values and simulation matches the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cap_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            cap_cnt_q <= 8'd0;
          end
        end
        RUN: begin
          cap_cnt_q <= cap_cnt_q + 8'd1;
          if (cap_cnt_q == LAST_CAP) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // The last capture is being compared on this edge.
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: sample the ALU's ports on every RUN edge.
  // NOTE: only the valid flag is reset; the vector payload is don't-care
  // while v1_q is low, so it needs no reset and stays a plain data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= (state_q == RUN);
    end
  end

  // Stage 1 payload capture (unreset data path).
  always_ff @(posedge clk) begin
    if (state_q == RUN) begin
      vec_q <= {E, S, A, B, Y, C};
    end
  end

  // Field views of the captured vector.
  logic       s1_e;
  logic [1:0] s1_s;
  logic [3:0] s1_a, s1_b, s1_y;
  logic       s1_c;
  assign {s1_e, s1_s, s1_a, s1_b, s1_y, s1_c} = vec_q;

  // Golden model: expected {Cx,Yx} for the captured operands.
  logic [4:0] exp_cy;
  logic       miss;
  // NOTE: exp_cy gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    exp_cy = 5'd0;
    if (s1_e) begin
      case (s1_s)
        2'b00: exp_cy = {1'b0, s1_a} + {1'b0, s1_b};
        // Zero-extended subtract: bit 4 is the borrow, set exactly when A<B.
        2'b01: exp_cy = {1'b0, s1_a} - {1'b0, s1_b};
        2'b10: exp_cy = {2'b00, (s1_a < s1_b), (s1_a == s1_b), (s1_a > s1_b)};
        default: exp_cy = {1'b0, s1_a & s1_b};
      endcase
    end
    // Case inequality makes an X/Z on the ALU outputs read as a mismatch.
    miss = ({s1_c, s1_y} !== exp_cy);
  end

  // Stage 2 next state: clear on run start, otherwise accumulate compares.
  always_comb begin
    mismatch_d = 1'b0;
    err_d      = err_q;
    chk_d      = chk_q;
    first_d    = first_q;
    if (run_clear) begin
      err_d   = '0;
      chk_d   = 8'd0;
      first_d = 16'd0;
    end else if (v1_q) begin
      chk_d      = chk_q + 8'd1;
      mismatch_d = miss;
      if (miss) begin
        if (err_q != ERR_MAX) begin
          err_d = err_q + ERR_W'(1);
        end
        // The counter saturates and never wraps, so zero means first failure.
        if (err_q == '0) begin
          first_d = vec_q;
        end
      end
    end
  end

  // Stage 2 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
      err_q      <= '0;
      chk_q      <= 8'd0;
      first_q    <= 16'd0;
    end else begin
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      chk_q      <= chk_d;
      first_q    <= first_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (err_q == '0);
  assign mismatch  = mismatch_q;
  assign err_count = err_q;
  assign chk_count = chk_q;
  assign first_err = first_q;

endmodule

// File: tb/tb_alu_response_checker.sv
// Directed bench for alu_response_checker. Three instances share the ALU-side
// stimulus: a 1-vector checker, a 64-vector checker and a 6-vector checker
// with a 2-bit error counter for the saturation case.
module tb_alu_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start64, start_s;
  logic       E;
  logic [1:0] S;
  logic [3:0] A, B, Y;
  logic       C;

  logic       b1, d1, p1, m1;
  logic [7:0] e1, c1;
  logic [15:0] f1;
  logic       b64, d64, p64, m64;
  logic [7:0] e64, c64;
  logic [15:0] f64;
  logic       bs, ds, ps, ms;
  logic [1:0] es;
  logic [7:0] cs;
  logic [15:0] fs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_response_checker #(.NUM_CHECKS(1), .ERR_W(8)) u_one (
    .clk(clk), .rst(rst), .start(start1),
    .E(E), .S(S), .A(A), .B(B), .Y(Y), .C(C),
    .busy(b1), .done(d1), .pass(p1), .mismatch(m1),
    .err_count(e1), .chk_count(c1), .first_err(f1)
  );

  alu_response_checker #(.NUM_CHECKS(64), .ERR_W(8)) u_sweep (
    .clk(clk), .rst(rst), .start(start64),
    .E(E), .S(S), .A(A), .B(B), .Y(Y), .C(C),
    .busy(b64), .done(d64), .pass(p64), .mismatch(m64),
    .err_count(e64), .chk_count(c64), .first_err(f64)
  );

  alu_response_checker #(.NUM_CHECKS(6), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_s),
    .E(E), .S(S), .A(A), .B(B), .Y(Y), .C(C),
    .busy(bs), .done(ds), .pass(ps), .mismatch(ms),
    .err_count(es), .chk_count(cs), .first_err(fs)
  );

  // Reference ALU behaviour, returned as {C,Y}.
  function automatic logic [4:0] alu_ref(input logic e, input logic [1:0] s,
                                         input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    if (!e) return 5'd0;
    case (s)
      2'd0: r = 5'(a) + 5'(b);
      2'd1: begin
        r[3:0] = a - b;
        r[4]   = (a < b);
      end
      2'd2: begin
        r = 5'd0;
        if (a < b)       r[2] = 1'b1;
        else if (a == b) r[1] = 1'b1;
        else             r[0] = 1'b1;
      end
      default: r = {1'b0, a & b};
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ok(input logic e, input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
    E = e; S = s; A = a; B = b;
    {C, Y} = alu_ref(e, s, a, b);
  endtask

  // 64 correct vectors through u_sweep; optionally pokes start mid-run,
  // which must be ignored.
  task automatic sweep64(input bit poke_start);
    int pulses;
    logic [3:0] a, b;
    pulses  = 0;
    start64 = 1'b1;
    step();
    start64 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      a = 4'((i * 7 + 3) % 16);
      b = 4'((i * 5 + 1) % 16);
      if (i == 2) begin a = 4'd7; b = 4'd7; end  // S=10, E=1, A==B
      drive_ok((i % 3) != 0, 2'(i % 4), a, b);
      start64 = poke_start && (i == 10);
      step();
      if (m64) pulses++;
    end
    start64 = 1'b0;
    step();
    if (m64) pulses++;
    check("sweep_done", d64, 1);
    check("sweep_busy", b64, 0);
    check("sweep_chk", c64, 64);
    check("sweep_err", e64, 0);
    check("sweep_pass", p64, 1);
    check("sweep_pulses", pulses, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start1 = 1'b0; start64 = 1'b0; start_s = 1'b0;
    drive_ok(1'b0, 2'd0, 4'd0, 4'd0);
    step();
    step();
    rst = 1'b0;

    // Reset state.
    check("rst_busy", b1, 0);
    check("rst_done", d1, 0);
    check("rst_pass", p1, 0);
    check("rst_mismatch", m1, 0);
    check("rst_err", e1, 0);
    check("rst_chk", c1, 0);
    check("rst_first", f1, 0);
    check("rst_sat_err", es, 0);

    // Correct add, 3+14 = 17 -> Y=0001 C=1.
    E = 1'b1; S = 2'b00; A = 4'd3; B = 4'd14; Y = 4'b0001; C = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("add_busy_t0", b1, 1);
    check("add_done_t0", d1, 0);
    step();
    check("add_done_t1", d1, 0);
    check("add_mismatch_t1", m1, 0);
    step();
    check("add_done_t2", d1, 1);
    check("add_busy_t2", b1, 0);
    check("add_pass", p1, 1);
    check("add_chk", c1, 1);
    check("add_mismatch", m1, 0);

    // Restart the cycle after done with a faulty subtract: expected 0101/1.
    E = 1'b1; S = 2'b01; A = 4'd3; B = 4'd14; Y = 4'b0100; C = 1'b0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("restart_done", d1, 0);
    check("restart_busy", b1, 1);
    check("restart_chk", c1, 0);
    step();
    check("fault_no_early_pulse", m1, 0);
    step();
    check("fault_mismatch", m1, 1);
    check("fault_err", e1, 1);
    check("fault_first", f1, 16'hA7C8);
    check("fault_done", d1, 1);
    check("fault_pass", p1, 0);
    step();
    check("fault_pulse_end", m1, 0);
    check("fault_err_hold", e1, 1);

    // Restart from DONE after a failure clears the statistics.
    drive_ok(1'b1, 2'b11, 4'd12, 4'd10);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("clr_first", f1, 0);
    check("clr_err", e1, 0);
    check("clr_busy", b1, 1);
    check("clr_pass", p1, 0);
    step();
    step();
    check("clr_run_pass", p1, 1);

    // 64-vector compare/AND/disable sweep with an ignored mid-run start.
    sweep64(1'b1);

    // Reset mid-run: inject failures, then reset with start held high.
    E = 1'b1; S = 2'b11; A = 4'd5; B = 4'd3; Y = 4'b0000; C = 1'b0;
    start64 = 1'b1;
    step();
    start64 = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("midrun_err", e64, 4);
    check("midrun_busy", b64, 1);
    check("midrun_first", f64, 16'hEA60);
    rst = 1'b1;
    start64 = 1'b1;
    step();
    rst = 1'b0;
    start64 = 1'b0;
    check("midrst_busy", b64, 0);
    check("midrst_done", d64, 0);
    check("midrst_pass", p64, 0);
    check("midrst_mismatch", m64, 0);
    check("midrst_err", e64, 0);
    check("midrst_chk", c64, 0);
    check("midrst_first", f64, 0);
    step();
    check("midrst_idle", b64, 0);
    sweep64(1'b0);

    // Saturation: Y stuck at 1111 on AND with B=0 for six vectors.
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      E = 1'b1; S = 2'b11; A = 4'(i + 1); B = 4'd0; Y = 4'b1111; C = 1'b0;
      step();
      check("sat_err_step", es, (i < 3) ? i : 3);
      check("sat_chk_step", cs, i);
      if (i >= 1) check("sat_first_step", fs, 16'hE21E);
    end
    step();
    check("sat_err_final", es, 3);
    check("sat_chk_final", cs, 6);
    check("sat_first_final", fs, 16'hE21E);
    check("sat_done", ds, 1);
    check("sat_pass", ps, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
